// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the convolution loop-nest controller.
package conv_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    typedef enum logic {
        Stride1 = 1'b0,
        Stride2 = 1'b1
    } stride_e;

    // Output extent along one axis: ceil(dim / S).
    function automatic int unsigned out_dim(input int unsigned dim, input stride_e stride);
        if (stride == Stride2) begin
            return (dim + 1) >> 1;
        end
        return dim;
    endfunction

endpackage

// File: rtl/loop_counter.sv
// Wrapping index counter with runtime maximum; wraps chain counters into a loop nest.
module loop_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst_n_in,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_max,
    output logic [WIDTH-1:0] o_cnt,
    output logic [WIDTH-1:0] o_cnt_next,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_at_max;

    // o_cnt_next lets the parent precompute registered values derived from the index.
    always_comb begin
        w_at_max = (r_cnt == i_max);
        o_wrap   = i_en && w_at_max;
        if (i_clr) begin
            o_cnt_next = '0;
        end else if (o_wrap) begin
            o_cnt_next = '0;
        end else if (i_en) begin
            o_cnt_next = r_cnt + WIDTH'(1);
        end else begin
            o_cnt_next = r_cnt;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= o_cnt_next;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/conv_loop_ctrl.sv
// Runtime-configurable loop-nest controller: walks out_y/out_x/out_ch/ky/kx/in_ch of a padded
// stride-1/2 convolution and issues one index tuple per valid/ready handshake.
module conv_loop_ctrl #(
    parameter int unsigned DIM_WIDTH = 8,
    parameter int unsigned CH_WIDTH  = 5,
    parameter int unsigned K_WIDTH   = 3
) (
    input  logic                        clk,
    input  logic                        arst_n_in,
    input  logic                        start,
    input  logic [DIM_WIDTH-1:0]        cfg_fm_width,
    input  logic [DIM_WIDTH-1:0]        cfg_fm_height,
    input  logic [CH_WIDTH-1:0]         cfg_in_ch,
    input  logic [CH_WIDTH-1:0]         cfg_out_ch,
    input  logic [K_WIDTH-1:0]          cfg_kernel_size,
    input  logic                        cfg_stride,
    output logic                        running,
    output logic                        fsm_done,
    output logic                        cfg_err,
    output logic                        step_valid,
    input  logic                        step_ready,
    output logic [DIM_WIDTH-1:0]        out_x,
    output logic [DIM_WIDTH-1:0]        out_y,
    output logic [CH_WIDTH-1:0]         out_ch,
    output logic [CH_WIDTH-1:0]         in_ch,
    output logic [K_WIDTH-1:0]          kx,
    output logic [K_WIDTH-1:0]          ky,
    output logic signed [DIM_WIDTH:0]   in_x,
    output logic signed [DIM_WIDTH:0]   in_y,
    output logic                        pad,
    output logic                        acc_first,
    output logic                        acc_last
);
    import conv_ctrl_pkg::*;

    state_e                    r_state;
    logic [DIM_WIDTH-1:0]      r_w;
    logic [DIM_WIDTH-1:0]      r_h;
    logic [CH_WIDTH-1:0]       r_in_ch;
    logic [CH_WIDTH-1:0]       r_out_ch;
    logic [K_WIDTH-1:0]        r_k;
    stride_e                   r_stride;
    logic                      r_running;
    logic                      r_fsm_done;
    logic                      r_cfg_err;
    logic                      r_step_valid;
    logic signed [DIM_WIDTH:0] r_in_x;
    logic signed [DIM_WIDTH:0] r_in_y;
    logic                      r_pad;
    logic                      r_acc_first;
    logic                      r_acc_last;

    logic                      w_accept;
    logic                      w_go;
    logic                      w_cfg_bad;
    logic                      w_fire;
    logic                      w_last;

    logic [CH_WIDTH-1:0]       w_max_ic;
    logic [CH_WIDTH-1:0]       w_max_oc;
    logic [K_WIDTH-1:0]        w_max_k;
    logic [DIM_WIDTH-1:0]      w_max_ox;
    logic [DIM_WIDTH-1:0]      w_max_oy;

    logic w_en_ic, w_en_kx, w_en_ky, w_en_oc, w_en_ox, w_en_oy;
    logic w_wrap_ic, w_wrap_kx, w_wrap_ky, w_wrap_oc, w_wrap_ox, w_wrap_oy;

    logic [CH_WIDTH-1:0]       w_nx_ic;
    logic [CH_WIDTH-1:0]       w_nx_oc;
    logic [K_WIDTH-1:0]        w_nx_kx;
    logic [K_WIDTH-1:0]        w_nx_ky;
    logic [DIM_WIDTH-1:0]      w_nx_ox;
    logic [DIM_WIDTH-1:0]      w_nx_oy;

    logic [DIM_WIDTH-1:0]      w_src_w;
    logic [DIM_WIDTH-1:0]      w_src_h;
    logic [CH_WIDTH-1:0]       w_src_ic;
    logic [K_WIDTH-1:0]        w_src_k;
    stride_e                   w_src_s;

    int                        w_step;
    int                        w_half;
    int                        w_ix;
    int                        w_iy;
    logic signed [DIM_WIDTH:0] w_nx_in_x;
    logic signed [DIM_WIDTH:0] w_nx_in_y;
    logic                      w_nx_pad;
    logic                      w_nx_acc_first;
    logic                      w_nx_acc_last;

    assign w_accept  = (r_state == StIdle) && start;
    // An even K (including zero) has no centre tap.
    assign w_cfg_bad = (cfg_fm_width == '0) || (cfg_fm_height == '0) || (cfg_in_ch == '0) ||
                       (cfg_out_ch == '0) || !cfg_kernel_size[0];
    assign w_go      = w_accept && !w_cfg_bad;
    assign w_fire    = r_step_valid && step_ready;

    assign w_max_ic = r_in_ch - CH_WIDTH'(1);
    assign w_max_oc = r_out_ch - CH_WIDTH'(1);
    assign w_max_k  = r_k - K_WIDTH'(1);
    assign w_max_ox = DIM_WIDTH'(out_dim(32'(r_w), r_stride) - 1);
    assign w_max_oy = DIM_WIDTH'(out_dim(32'(r_h), r_stride) - 1);

    assign w_en_ic = w_fire;
    assign w_en_kx = w_en_ic && w_wrap_ic;
    assign w_en_ky = w_en_kx && w_wrap_kx;
    assign w_en_oc = w_en_ky && w_wrap_ky;
    assign w_en_ox = w_en_oc && w_wrap_oc;
    assign w_en_oy = w_en_ox && w_wrap_ox;
    assign w_last  = w_wrap_oy;

    loop_counter #(.WIDTH(CH_WIDTH)) u_cnt_ic (
        .clk        (clk),
        .arst_n_in  (arst_n_in),
        .i_clr      (w_accept),
        .i_en       (w_en_ic),
        .i_max      (w_max_ic),
        .o_cnt      (in_ch),
        .o_cnt_next (w_nx_ic),
        .o_wrap     (w_wrap_ic)
    );

    loop_counter #(.WIDTH(K_WIDTH)) u_cnt_kx (
        .clk        (clk),
        .arst_n_in  (arst_n_in),
        .i_clr      (w_accept),
        .i_en       (w_en_kx),
        .i_max      (w_max_k),
        .o_cnt      (kx),
        .o_cnt_next (w_nx_kx),
        .o_wrap     (w_wrap_kx)
    );

    loop_counter #(.WIDTH(K_WIDTH)) u_cnt_ky (
        .clk        (clk),
        .arst_n_in  (arst_n_in),
        .i_clr      (w_accept),
        .i_en       (w_en_ky),
        .i_max      (w_max_k),
        .o_cnt      (ky),
        .o_cnt_next (w_nx_ky),
        .o_wrap     (w_wrap_ky)
    );

    loop_counter #(.WIDTH(CH_WIDTH)) u_cnt_oc (
        .clk        (clk),
        .arst_n_in  (arst_n_in),
        .i_clr      (w_accept),
        .i_en       (w_en_oc),
        .i_max      (w_max_oc),
        .o_cnt      (out_ch),
        .o_cnt_next (w_nx_oc),
        .o_wrap     (w_wrap_oc)
    );

    loop_counter #(.WIDTH(DIM_WIDTH)) u_cnt_ox (
        .clk        (clk),
        .arst_n_in  (arst_n_in),
        .i_clr      (w_accept),
        .i_en       (w_en_ox),
        .i_max      (w_max_ox),
        .o_cnt      (out_x),
        .o_cnt_next (w_nx_ox),
        .o_wrap     (w_wrap_ox)
    );

    loop_counter #(.WIDTH(DIM_WIDTH)) u_cnt_oy (
        .clk        (clk),
        .arst_n_in  (arst_n_in),
        .i_clr      (w_accept),
        .i_en       (w_en_oy),
        .i_max      (w_max_oy),
        .o_cnt      (out_y),
        .o_cnt_next (w_nx_oy),
        .o_wrap     (w_wrap_oy)
    );

    // The first tuple is registered on the start edge, so derive it from the live cfg inputs.
    assign w_src_w  = w_go ? cfg_fm_width    : r_w;
    assign w_src_h  = w_go ? cfg_fm_height   : r_h;
    assign w_src_ic = w_go ? cfg_in_ch       : r_in_ch;
    assign w_src_k  = w_go ? cfg_kernel_size : r_k;
    assign w_src_s  = w_go ? stride_e'(cfg_stride) : r_stride;

    // Wide signed arithmetic so pad stays exact even where in_x/in_y wrap on output.
    always_comb begin
        w_step         = (w_src_s == Stride2) ? 2 : 1;
        w_half         = int'(w_src_k >> 1);
        w_ix           = int'(w_nx_ox) * w_step + int'(w_nx_kx) - w_half;
        w_iy           = int'(w_nx_oy) * w_step + int'(w_nx_ky) - w_half;
        w_nx_in_x      = (DIM_WIDTH + 1)'(w_ix);
        w_nx_in_y      = (DIM_WIDTH + 1)'(w_iy);
        w_nx_pad       = (w_ix < 0) || (w_ix >= int'(w_src_w)) ||
                         (w_iy < 0) || (w_iy >= int'(w_src_h));
        w_nx_acc_first = (w_nx_ic == '0) && (w_nx_kx == '0) && (w_nx_ky == '0);
        w_nx_acc_last  = (w_nx_ic == w_src_ic - CH_WIDTH'(1)) &&
                         (w_nx_kx == w_src_k - K_WIDTH'(1)) &&
                         (w_nx_ky == w_src_k - K_WIDTH'(1));
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_state      <= StIdle;
            r_w          <= '0;
            r_h          <= '0;
            r_in_ch      <= '0;
            r_out_ch     <= '0;
            r_k          <= '0;
            r_stride     <= Stride1;
            r_running    <= 1'b0;
            r_fsm_done   <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_step_valid <= 1'b0;
            r_in_x       <= '0;
            r_in_y       <= '0;
            r_pad        <= 1'b0;
            r_acc_first  <= 1'b0;
            r_acc_last   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_fsm_done <= 1'b0;
                    if (start) begin
                        r_w       <= cfg_fm_width;
                        r_h       <= cfg_fm_height;
                        r_in_ch   <= cfg_in_ch;
                        r_out_ch  <= cfg_out_ch;
                        r_k       <= cfg_kernel_size;
                        r_stride  <= stride_e'(cfg_stride);
                        r_cfg_err <= w_cfg_bad;
                        if (w_cfg_bad) begin
                            r_state    <= StDone;
                            r_fsm_done <= 1'b1;
                        end else begin
                            r_state      <= StRun;
                            r_running    <= 1'b1;
                            r_step_valid <= 1'b1;
                            r_in_x       <= w_nx_in_x;
                            r_in_y       <= w_nx_in_y;
                            r_pad        <= w_nx_pad;
                            r_acc_first  <= w_nx_acc_first;
                            r_acc_last   <= w_nx_acc_last;
                        end
                    end
                end
                StRun: begin
                    if (w_fire) begin
                        if (w_last) begin
                            r_state      <= StDone;
                            r_running    <= 1'b0;
                            r_step_valid <= 1'b0;
                            r_fsm_done   <= 1'b1;
                        end else begin
                            r_in_x      <= w_nx_in_x;
                            r_in_y      <= w_nx_in_y;
                            r_pad       <= w_nx_pad;
                            r_acc_first <= w_nx_acc_first;
                            r_acc_last  <= w_nx_acc_last;
                        end
                    end
                end
                StDone: begin
                    r_fsm_done <= 1'b0;
                    r_state    <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign running    = r_running;
    assign fsm_done   = r_fsm_done;
    assign cfg_err    = r_cfg_err;
    assign step_valid = r_step_valid;
    assign in_x       = r_in_x;
    assign in_y       = r_in_y;
    assign pad        = r_pad;
    assign acc_first  = r_acc_first;
    assign acc_last   = r_acc_last;

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// Self-checking bench for conv_loop_ctrl: table-driven configs, random configs and stalls,
// checked against an index-decomposition model of the loop nest.
module tb_conv_loop_ctrl;

    logic              clk;
    logic              arst_n_in;
    logic              start;
    logic [7:0]        cfg_fm_width;
    logic [7:0]        cfg_fm_height;
    logic [4:0]        cfg_in_ch;
    logic [4:0]        cfg_out_ch;
    logic [2:0]        cfg_kernel_size;
    logic              cfg_stride;
    logic              running;
    logic              fsm_done;
    logic              cfg_err;
    logic              step_valid;
    logic              step_ready;
    logic [7:0]        out_x;
    logic [7:0]        out_y;
    logic [4:0]        out_ch;
    logic [4:0]        in_ch;
    logic [2:0]        kx;
    logic [2:0]        ky;
    logic signed [8:0] in_x;
    logic signed [8:0] in_y;
    logic              pad;
    logic              acc_first;
    logic              acc_last;

    conv_loop_ctrl #(
        .DIM_WIDTH (8),
        .CH_WIDTH  (5),
        .K_WIDTH   (3)
    ) u_dut (
        .clk             (clk),
        .arst_n_in       (arst_n_in),
        .start           (start),
        .cfg_fm_width    (cfg_fm_width),
        .cfg_fm_height   (cfg_fm_height),
        .cfg_in_ch       (cfg_in_ch),
        .cfg_out_ch      (cfg_out_ch),
        .cfg_kernel_size (cfg_kernel_size),
        .cfg_stride      (cfg_stride),
        .running         (running),
        .fsm_done        (fsm_done),
        .cfg_err         (cfg_err),
        .step_valid      (step_valid),
        .step_ready      (step_ready),
        .out_x           (out_x),
        .out_y           (out_y),
        .out_ch          (out_ch),
        .in_ch           (in_ch),
        .kx              (kx),
        .ky              (ky),
        .in_x            (in_x),
        .in_y            (in_y),
        .pad             (pad),
        .acc_first       (acc_first),
        .acc_last        (acc_last)
    );

    typedef struct {
        int w, h, ic, oc, k, s;
        bit exp_err;
        int exp_total;
        bit has_ends;
        int f_ix, f_iy, l_ix, l_iy;
        bit l_pad;
    } vec_t;

    typedef struct {
        int ox, oy, oc, ic, kx, ky, ix, iy, pad, af, al;
    } tup_t;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int w, h, ic, oc, k, s, input bit err, input int total,
                                input bit ends, input int fx, fy, lx, ly, input bit lpad);
        vec_t v;
        v.w = w; v.h = h; v.ic = ic; v.oc = oc; v.k = k; v.s = s;
        v.exp_err = err; v.exp_total = total; v.has_ends = ends;
        v.f_ix = fx; v.f_iy = fy; v.l_ix = lx; v.l_iy = ly; v.l_pad = lpad;
        return v;
    endfunction

    function automatic int stride_of(input vec_t v);
        return (v.s != 0) ? 2 : 1;
    endfunction

    function automatic int model_total(input vec_t v);
        int sv = stride_of(v);
        return ((v.w + sv - 1) / sv) * ((v.h + sv - 1) / sv) * v.oc * v.k * v.k * v.ic;
    endfunction

    // Tuple n of the iteration space by mixed-radix decomposition, innermost in_ch first.
    function automatic tup_t model(input vec_t v, input int n);
        tup_t t;
        int   sv = stride_of(v);
        int   ow = (v.w + sv - 1) / sv;
        int   half = (v.k - 1) / 2;
        t.ic = n % v.ic; n = n / v.ic;
        t.kx = n % v.k;  n = n / v.k;
        t.ky = n % v.k;  n = n / v.k;
        t.oc = n % v.oc; n = n / v.oc;
        t.ox = n % ow;
        t.oy = n / ow;
        t.ix = t.ox * sv + t.kx - half;
        t.iy = t.oy * sv + t.ky - half;
        t.pad = (t.ix < 0 || t.ix >= v.w || t.iy < 0 || t.iy >= v.h) ? 1 : 0;
        t.af = (t.ic == 0 && t.kx == 0 && t.ky == 0) ? 1 : 0;
        t.al = (t.ic == v.ic - 1 && t.kx == v.k - 1 && t.ky == v.k - 1) ? 1 : 0;
        return t;
    endfunction

    function automatic tup_t grab();
        tup_t t;
        t.ox = int'(out_x); t.oy = int'(out_y); t.oc = int'(out_ch); t.ic = int'(in_ch);
        t.kx = int'(kx); t.ky = int'(ky); t.ix = int'(in_x); t.iy = int'(in_y);
        t.pad = int'(pad); t.af = int'(acc_first); t.al = int'(acc_last);
        return t;
    endfunction

    function automatic longint pack(input tup_t t);
        longint p;
        p = longint'(t.ox & 255);
        p = (p << 8) | longint'(t.oy & 255);
        p = (p << 5) | longint'(t.oc & 31);
        p = (p << 5) | longint'(t.ic & 31);
        p = (p << 3) | longint'(t.kx & 7);
        p = (p << 3) | longint'(t.ky & 7);
        p = (p << 9) | longint'(t.ix & 511);
        p = (p << 9) | longint'(t.iy & 511);
        p = (p << 3) | longint'(((t.pad & 1) << 2) | ((t.af & 1) << 1) | (t.al & 1));
        return p;
    endfunction

    task automatic cmp_tuple(input int idx, input tup_t got, input tup_t ex);
        chk($sformatf("out_x@%0d", idx), got.ox, ex.ox);
        chk($sformatf("out_y@%0d", idx), got.oy, ex.oy);
        chk($sformatf("out_ch@%0d", idx), got.oc, ex.oc);
        chk($sformatf("in_ch@%0d", idx), got.ic, ex.ic);
        chk($sformatf("kx@%0d", idx), got.kx, ex.kx);
        chk($sformatf("ky@%0d", idx), got.ky, ex.ky);
        chk($sformatf("in_x@%0d", idx), got.ix, ex.ix);
        chk($sformatf("in_y@%0d", idx), got.iy, ex.iy);
        chk($sformatf("pad@%0d", idx), got.pad, ex.pad);
        chk($sformatf("acc_first@%0d", idx), got.af, ex.af);
        chk($sformatf("acc_last@%0d", idx), got.al, ex.al);
    endtask

    task automatic check_all_zero(input string name);
        chk(name, longint'({running, fsm_done, cfg_err, step_valid, out_x, out_y, out_ch, in_ch,
                            kx, ky, in_x, in_y, pad, acc_first, acc_last}), 0);
    endtask

    // Called at a negedge; pulses start and leaves cfg scrambled to prove it was latched.
    task automatic do_start(input vec_t v);
        cfg_fm_width    = 8'(v.w);
        cfg_fm_height   = 8'(v.h);
        cfg_in_ch       = 5'(v.ic);
        cfg_out_ch      = 5'(v.oc);
        cfg_kernel_size = 3'(v.k);
        cfg_stride      = 1'(v.s);
        start           = 1'b1;
        @(negedge clk);
        start           = 1'b0;
        cfg_fm_width    = 8'($urandom);
        cfg_fm_height   = 8'($urandom);
        cfg_in_ch       = 5'($urandom);
        cfg_out_ch      = 5'($urandom);
        cfg_kernel_size = 3'($urandom);
        cfg_stride      = 1'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input int pct, input bit poke);
        int   idx = 0;
        int   cyc = 0;
        int   total;
        int   bound;
        bit   stalled = 1'b0;
        bit   rdy;
        tup_t cur, prev, ex;
        total = model_total(v);
        bound = total * 10 + 100;
        step_ready = 1'b0;
        do_start(v);
        chk("cfg_err_after_start", cfg_err, v.exp_err);
        if (v.exp_err) begin
            chk("err_valid", step_valid, 0);
            chk("err_running", running, 0);
            chk("err_done", fsm_done, 1);
            @(negedge clk);
            chk("err_done_clr", fsm_done, 0);
            chk("err_hold", cfg_err, 1);
            return;
        end
        chk("running_first", running, 1);
        chk("valid_first", step_valid, 1);
        chk("done_low_first", fsm_done, 0);
        while (step_valid && cyc < bound) begin
            cur = grab();
            if (stalled) chk($sformatf("stall_hold@%0d", idx), pack(cur), pack(prev));
            rdy        = ($urandom_range(99) < pct);
            step_ready = rdy;
            start      = poke && (cyc == 7);
            if (rdy) begin
                ex = model(v, idx);
                cmp_tuple(idx, cur, ex);
                if (v.has_ends && idx == 0) begin
                    chk("first_in_x", cur.ix, v.f_ix);
                    chk("first_in_y", cur.iy, v.f_iy);
                end
                if (v.has_ends && idx == v.exp_total - 1) begin
                    chk("last_in_x", cur.ix, v.l_ix);
                    chk("last_in_y", cur.iy, v.l_iy);
                    chk("last_pad", cur.pad, v.l_pad);
                end
                idx++;
            end
            stalled = !rdy;
            prev    = cur;
            cyc++;
            @(negedge clk);
        end
        start      = 1'b0;
        step_ready = 1'b0;
        chk("cycle_bound_expired", (cyc >= bound) ? 1 : 0, 0);
        chk("handshake_count", idx, v.exp_total);
        chk("end_valid", step_valid, 0);
        chk("end_running", running, 0);
        chk("end_done", fsm_done, 1);
        @(negedge clk);
        chk("done_clr", fsm_done, 0);
        chk("idle_valid", step_valid, 0);
    endtask

    initial begin
        vec_t rv;
        int   kpick[4];
        kpick[0] = 1; kpick[1] = 3; kpick[2] = 3; kpick[3] = 5;

        //            w  h  ic oc k  s  err total ends fx  fy  lx  ly  lpad
        vecs[0] = mk(4, 4, 2, 2, 3, 0, 0, 576,  1,  -1, -1,  4,  4, 1);
        vecs[1] = mk(4, 4, 0, 2, 3, 0, 1, 0,    0,   0,  0,  0,  0, 0);
        vecs[2] = mk(5, 3, 1, 1, 3, 1, 0, 54,   1,  -1, -1,  5,  3, 1);
        vecs[3] = mk(4, 4, 1, 1, 2, 0, 1, 0,    0,   0,  0,  0,  0, 0);
        vecs[4] = mk(1, 1, 1, 1, 1, 0, 0, 1,    1,   0,  0,  0,  0, 0);
        vecs[5] = mk(3, 2, 1, 2, 1, 1, 0, 4,    1,   0,  0,  2,  0, 0);
        vecs[6] = mk(0, 4, 1, 1, 3, 0, 1, 0,    0,   0,  0,  0,  0, 0);
        vecs[7] = mk(6, 5, 3, 1, 5, 0, 0, 2250, 1,  -2, -2,  7,  6, 1);

        arst_n_in       = 1'b0;
        start           = 1'b0;
        step_ready      = 1'b0;
        cfg_fm_width    = '0;
        cfg_fm_height   = '0;
        cfg_in_ch       = '0;
        cfg_out_ch      = '0;
        cfg_kernel_size = '0;
        cfg_stride      = 1'b0;
        #1;
        check_all_zero("reset_outputs");
        #20;
        @(negedge clk);
        arst_n_in = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset");

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], 100, (i == 0));
        end

        // Same config as the first vector with half the cycles stalled.
        run_vec(vecs[0], 50, 1'b0);

        // Asynchronous reset mid-run, then a full replay from tuple 0.
        do_start(vecs[0]);
        step_ready = 1'b1;
        repeat (100) @(negedge clk);
        chk("pre_reset_tuple", pack(grab()), pack(model(vecs[0], 100)));
        #2;
        arst_n_in = 1'b0;
        #1;
        check_all_zero("midrun_reset_outputs");
        step_ready = 1'b0;
        @(negedge clk);
        arst_n_in = 1'b1;
        @(negedge clk);
        run_vec(vecs[0], 100, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rv = mk($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 2),
                    $urandom_range(1, 2), kpick[$urandom_range(0, 3)], $urandom_range(0, 1),
                    1'b0, 0, 1'b0, 0, 0, 0, 0, 1'b0);
            rv.exp_total = model_total(rv);
            run_vec(rv, $urandom_range(40, 100), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_loop_ctrl.md
# conv_loop_ctrl

Runtime-configurable loop-nest controller for the convolution accelerator. It walks the full output-stationary iteration space (output row/column, output channel, kernel row/column, input channel) of a padded "same"-style convolution with stride 1 or 2, and emits one index tuple per valid/ready handshake. It sits between the top-level start/running/fsm_done control and the datapath/memory address generators. It replaces the previous fixed-size controller: map size, channel counts and kernel size are per-run inputs, and it adds stride-2 and padding detection.

## Interface

- DIM_WIDTH, 8, width of feature-map dimensions and output x/y indices
- CH_WIDTH, 5, width of channel counts and channel indices
- K_WIDTH, 3, width of kernel size and kernel indices

- clk  input  1  clock
- arst_n_in  input  1  asynchronous active-low reset
- start  input  1  start request, sampled in IDLE only
- cfg_fm_width, cfg_fm_height  input  DIM_WIDTH  input map size
- cfg_in_ch, cfg_out_ch  input  CH_WIDTH  channel counts
- cfg_kernel_size  input  K_WIDTH  odd kernel size K
- cfg_stride  input  1  0 = stride 1, 1 = stride 2
- running  output  1  high from the cycle after accepted start until the final handshake
- fsm_done  output  1  one-cycle pulse after the final handshake
- cfg_err  output  1  latched config error; cleared on next accepted start
- step_valid  output  1  index tuple valid
- step_ready  input  1  consumer accepts tuple
- out_x, out_y  output  DIM_WIDTH  output pixel
- out_ch  output  CH_WIDTH  output channel
- in_ch  output  CH_WIDTH  input channel
- kx, ky  output  K_WIDTH  kernel tap
- in_x, in_y  output  DIM_WIDTH+1 signed  input coordinate
- pad  output  1  in_x/in_y outside map; consumer substitutes zero
- acc_first, acc_last  output  1  first/last step of the current output element

## Operation

- States: IDLE, RUN, DONE.
- IDLE, start=1: latch all cfg_* inputs and clear counters and cfg_err.
  - Any of width, height, in_ch, out_ch or K equal to zero, or K even: set cfg_err and go to DONE.
  - Otherwise go to RUN.
- Later cfg_* changes are ignored until the next accepted start.
- RUN: step_valid=1. A tuple advances only on step_valid && step_ready.
- Loop order, innermost first: in_ch, kx, ky, out_ch, out_x, out_y. Each counter wraps to 0 at its limit and carries into the next.
- Output dims: out_w = ceil(W/S), out_h = ceil(H/S), where S = 1 or 2.
- Coordinate arithmetic is signed, DIM_WIDTH+1 bits:
  - in_x = out_x*S + kx - (K-1)/2
  - in_y = out_y*S + ky - (K-1)/2
  - pad = in_x<0 | in_x>=W | in_y<0 | in_y>=H.
- acc_first = (in_ch,kx,ky all 0); acc_last = (all three at their maximum).
- Total handshakes = out_h*out_w*out_ch*K*K*in_ch.
- Handshake on the last tuple: go to DONE.
- DONE: fsm_done=1 for one cycle, then IDLE.
- start outside IDLE is ignored.

## Timing

- Reset value of every output is 0. Reset is asynchronous and may occur mid-run: the block goes to IDLE immediately, with no pending state.
- Start accepted at edge N:
  - from edge N, running=1 and step_valid=1 with the first tuple;
  - on a config error, fsm_done=1 from edge N for one cycle, with running=0 and step_valid=0.
- With ready held high, one tuple is issued per cycle.
- While step_valid && !step_ready, all tuple outputs hold stable.
- Final handshake at edge M:
  - at edge M: running=0, step_valid=0, fsm_done=1;
  - at edge M+1: fsm_done=0 and the block is in IDLE;
  - the earliest next start is sampled at edge M+1 and takes effect at edge M+2.
- All outputs are registered; there is no combinational ready-to-valid path.

## Structure

- Package conv_ctrl_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the stride enum;
  - the function out_dim(dim, stride) that computes ceil(dim/S).
- Sub-module loop_counter: a parametrised width counter with enable, runtime max, and wrap output. It is instantiated six times and chained by the wrap outputs.

## Test plan

1. W=H=4, in_ch=2, out_ch=2, K=3, S=1, ready=1.
   - Exactly 576 consecutive handshakes, then fsm_done one cycle after the last.
   - First tuple: in_x=in_y=-1, pad=1, acc_first=1.
2. W=5, H=3, in=out=1, K=3, S=2.
   - out_w=3, out_h=2, 54 steps.
   - Last tuple: out_x=2, out_y=1, kx=ky=2, in_x=5, in_y=3, pad=1, acc_last=1.
3. Scenario 1 with random 50% step_ready.
   - Accepted tuple sequence is identical to scenario 1.
   - Outputs are stable during every stall.
4. cfg_in_ch=0 (and separately K=2).
   - No step_valid, cfg_err=1, fsm_done pulses one cycle after start.
   - A following valid start clears cfg_err.
5. Reset asserted after 100 handshakes of scenario 1.
   - All outputs 0 immediately.
   - A new start replays the sequence from tuple 0.
6. W=H=1, in=out=1, K=1.
   - Exactly one tuple, with acc_first=acc_last=1, pad=0, in_x=in_y=0.
   - start pulsed during RUN in scenario 1 has no effect.
